// File: rtl/fu_pkg.sv
// fu_pkg: shared definitions for the queued functional-unit stage.
//   - fu_state_t  : sequencer states (IDLE, OP1, OP2, WAIT, HOLD)
//   - CSR_*       : bit positions inside alu_csr_in / alu_csr_out
//   - FU_CSR_W    : width of both CSR handshake buses
// The command and result entry structs depend on the top-level width
// parameters, so they are declared inside fu_queue_stage next to those
// parameters. Their field order is documented here so other blocks can
// rely on it:
//   command entry : {aluop, op1, op2, tag}
//   result entry  : {data, tag, err}
package fu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_OP1  = 3'd1,
    ST_OP2  = 3'd2,
    ST_WAIT = 3'd3,
    ST_HOLD = 3'd4
  } fu_state_t;

  localparam int unsigned FU_CSR_W = 3;

  // alu_csr_in bits (driven towards the ALU)
  localparam int unsigned CSR_PROTECT = 0;
  localparam int unsigned CSR_OP1V    = 1;
  localparam int unsigned CSR_OP2V    = 2;

  // alu_csr_out bits (returned by the ALU)
  localparam int unsigned CSR_OP1RDY  = 0;
  localparam int unsigned CSR_OP2RDY  = 1;
  localparam int unsigned CSR_RESV    = 2;

endpackage

// File: rtl/fu_sync_fifo.sv
// fu_sync_fifo: single-clock FIFO with extended-pointer full/empty.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset (empties FIFO)
//   push, push_data       : write request; ignored while full
//   pop                   : read request; ignored while empty
//   pop_data              : head entry (valid only while !empty)
//   full, empty           : occupancy flags
// DEPTH must be a power of two and at least 2.
module fu_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the
  // address bits coincide.
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage carries no reset; emptiness is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/fu_queue_stage.sv
// fu_queue_stage: queued front end for the external ALU.
// Commands arrive on a valid/ready request port, wait in a command FIFO,
// are walked one at a time through the ALU's three-bit CSR handshake, and
// the tagged results leave through a result FIFO on a valid/ready port.
// Ports:
//   clk, reset_n                          : clock, async active-low reset
//   req_valid/req_ready                   : request handshake
//   req_aluop, req_op1, req_op2, req_tag  : request payload
//   rsp_valid/rsp_ready                   : response handshake
//   rsp_data, rsp_tag, rsp_err            : response payload
//   alu_aluop, alu_op1, alu_op2           : registered ALU operands
//   alu_csr_in  : [0] protect result, [1] OP1 valid, [2] OP2 valid
//   alu_csr_out : [0] ready for OP1, [1] ready for OP2, [2] result valid
//   alu_op3                               : ALU result
// Optional feature macro: FU_WDOG_EN enables a per-state watchdog of
// WDOG_CYCLES cycles that aborts a stuck command with rsp_err = 1.
module fu_queue_stage
  import fu_pkg::*;
#(
  parameter int unsigned DBITS       = 32,
  parameter int unsigned ALUOPBITS   = 4,
  parameter int unsigned TAGBITS     = 4,
  parameter int unsigned CMD_DEPTH   = 4,
  parameter int unsigned RES_DEPTH   = 4,
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ALUOPBITS-1:0] req_aluop,
  input  logic [DBITS-1:0]     req_op1,
  input  logic [DBITS-1:0]     req_op2,
  input  logic [TAGBITS-1:0]   req_tag,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DBITS-1:0]     rsp_data,
  output logic [TAGBITS-1:0]   rsp_tag,
  output logic                 rsp_err,
  output logic [ALUOPBITS-1:0] alu_aluop,
  output logic [DBITS-1:0]     alu_op1,
  output logic [DBITS-1:0]     alu_op2,
  output logic [FU_CSR_W-1:0]  alu_csr_in,
  input  logic [FU_CSR_W-1:0]  alu_csr_out,
  input  logic [DBITS-1:0]     alu_op3
);

  typedef struct packed {
    logic [ALUOPBITS-1:0] aluop;
    logic [DBITS-1:0]     op1;
    logic [DBITS-1:0]     op2;
    logic [TAGBITS-1:0]   tag;
  } cmd_entry_t;

  typedef struct packed {
    logic [DBITS-1:0]   data;
    logic [TAGBITS-1:0] tag;
    logic               err;
  } res_entry_t;

  cmd_entry_t           cmd_in;
  cmd_entry_t           cmd_head;
  res_entry_t           res_in;
  res_entry_t           res_head;
  logic                 cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic                 res_push, res_pop, res_full, res_empty;
  logic                 rdy_en_q;
  fu_state_t            state_q, state_d;
  logic                 timeout;
  logic [FU_CSR_W-1:0]  csr_q, csr_d;
  logic [TAGBITS-1:0]   tag_q;
  logic [ALUOPBITS-1:0] aluop_q;
  logic [DBITS-1:0]     op1_q, op2_q;

  // ---- request side: accept into the command FIFO ----
  // rdy_en_q keeps req_ready low during reset and raises it on the first
  // clock after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdy_en_q <= 1'b0;
    else          rdy_en_q <= 1'b1;
  end

  assign req_ready = rdy_en_q && !cmd_full;
  assign cmd_push  = req_valid && req_ready;

  always_comb begin
    cmd_in       = '0;
    cmd_in.aluop = req_aluop;
    cmd_in.op1   = req_op1;
    cmd_in.op2   = req_op2;
    cmd_in.tag   = req_tag;
  end

  fu_sync_fifo #(
    .WIDTH ($bits(cmd_entry_t)),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (cmd_push),
    .push_data (cmd_in),
    .pop       (cmd_pop),
    .pop_data  (cmd_head),
    .full      (cmd_full),
    .empty     (cmd_empty)
  );

  // ---- sequencer: state register ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

`ifdef FU_WDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_cnt_q;
  logic              wdog_hit_q;
  logic              wdog_busy;
  logic              wdog_expire;

  assign wdog_busy   = (state_q == ST_OP1) || (state_q == ST_OP2) || (state_q == ST_WAIT);
  assign wdog_expire = wdog_busy && (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1));

  // Counts cycles spent in the current handshake state; any state change
  // restarts it so each handshake step gets the full budget.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_cnt_q <= '0;
      wdog_hit_q <= 1'b0;
    end else begin
      if (state_d != state_q) wdog_cnt_q <= '0;
      else if (wdog_busy)     wdog_cnt_q <= wdog_cnt_q + 1'b1;
      if (timeout)       wdog_hit_q <= 1'b1;
      else if (res_push) wdog_hit_q <= 1'b0;
    end
  end
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = (WDOG_CYCLES == 0);
`endif

  // ---- sequencer: next-state logic ----
  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    case (state_q)
      ST_IDLE: if (!cmd_empty)                state_d = ST_OP1;
      ST_OP1:  if (alu_csr_out[CSR_OP1RDY])   state_d = ST_OP2;
      ST_OP2:  if (alu_csr_out[CSR_OP2RDY])   state_d = ST_WAIT;
      ST_WAIT: if (alu_csr_out[CSR_RESV])     state_d = ST_HOLD;
      ST_HOLD: if (!res_full)                 state_d = ST_IDLE;
      default:                                state_d = ST_IDLE;
    endcase
`ifdef FU_WDOG_EN
    // Abort only when the ALU did not respond this cycle.
    if (wdog_expire && (state_d == state_q)) begin
      state_d = ST_HOLD;
      timeout = 1'b1;
    end
`endif
  end

  // ---- sequencer: output logic (FIFO strobes and next CSR value) ----
  always_comb begin
    cmd_pop = 1'b0;
    res_push = 1'b0;
    csr_d   = csr_q;
    case (state_q)
      ST_IDLE: cmd_pop = !cmd_empty;
      ST_OP1: begin
        if (state_d == ST_OP2) csr_d[CSR_OP1V] = 1'b1;
      end
      ST_OP2: begin
        csr_d[CSR_OP1V] = 1'b0;
        if (state_d == ST_WAIT) csr_d[CSR_OP2V] = 1'b1;
      end
      ST_WAIT: begin
        csr_d[CSR_OP2V] = 1'b0;
        if ((state_d == ST_HOLD) && !timeout) csr_d[CSR_PROTECT] = 1'b1;
      end
      ST_HOLD: begin
        res_push = !res_full;
        if (!res_full) csr_d[CSR_PROTECT] = 1'b0;
      end
      default: csr_d = '0;
    endcase
    if (timeout) begin
      csr_d[CSR_OP1V] = 1'b0;
      csr_d[CSR_OP2V] = 1'b0;
    end
  end

  // ---- ALU-facing registers: loaded on command pop ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csr_q   <= '0;
      aluop_q <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      tag_q   <= '0;
    end else begin
      csr_q <= csr_d;
      if (cmd_pop) begin
        aluop_q <= cmd_head.aluop;
        op1_q   <= cmd_head.op1;
        op2_q   <= cmd_head.op2;
        tag_q   <= cmd_head.tag;
      end
    end
  end

  assign alu_csr_in = csr_q;
  assign alu_aluop  = aluop_q;
  assign alu_op1    = op1_q;
  assign alu_op2    = op2_q;

  // ---- result side: push from HOLD, drain on response handshake ----
  always_comb begin
    res_in     = '0;
    res_in.tag = tag_q;
`ifdef FU_WDOG_EN
    res_in.data = wdog_hit_q ? '0 : alu_op3;
    res_in.err  = wdog_hit_q;
`else
    res_in.data = alu_op3;
    res_in.err  = 1'b0;
`endif
  end

  assign res_pop = rsp_valid && rsp_ready;

  fu_sync_fifo #(
    .WIDTH ($bits(res_entry_t)),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (res_push),
    .push_data (res_in),
    .pop       (res_pop),
    .pop_data  (res_head),
    .full      (res_full),
    .empty     (res_empty)
  );

  // Payload is forced to zero while empty so stale or uninitialised
  // storage never reaches the response port.
  assign rsp_valid = !res_empty;
  assign rsp_data  = res_empty ? '0 : res_head.data;
  assign rsp_tag   = res_empty ? '0 : res_head.tag;
  assign rsp_err   = res_empty ? 1'b0 : res_head.err;

endmodule

// File: tb/tb_fu_queue_stage.sv
// Directed bench for fu_queue_stage with a behavioural ALU and an
// in-order result scoreboard.
module tb_fu_queue_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready;
  logic [3:0]  req_aluop;
  logic [31:0] req_op1, req_op2;
  logic [3:0]  req_tag;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic        rsp_err;
  logic [3:0]  alu_aluop;
  logic [31:0] alu_op1, alu_op2, alu_op3;
  logic [2:0]  alu_csr_in, alu_csr_out;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] exp_data[$];
  logic [3:0]  exp_tag[$];
  logic [31:0] got_data[$];
  logic [3:0]  got_tag[$];
  logic        got_err[$];

  logic [2:0]  csr_seq [1:5];

  always #5 clk = ~clk;

  fu_queue_stage #(
    .DBITS(32), .ALUOPBITS(4), .TAGBITS(4),
    .CMD_DEPTH(4), .RES_DEPTH(4), .WDOG_CYCLES(16)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_aluop(req_aluop), .req_op1(req_op1), .req_op2(req_op2), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .alu_aluop(alu_aluop), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_csr_in(alu_csr_in), .alu_csr_out(alu_csr_out), .alu_op3(alu_op3)
  );

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_op3 = alu_f(alu_aluop, alu_op1, alu_op2);

  // Capture each response handshake between edges, where all inputs and
  // registered outputs are stable.
  always @(negedge clk) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      got_data.push_back(rsp_data);
      got_tag.push_back(rsp_tag);
      got_err.push_back(rsp_err);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    exp_data.delete(); exp_tag.delete();
    got_data.delete(); got_tag.delete(); got_err.delete();
  endtask

  task automatic drive_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    bit done = 1'b0;
    req_valid = 1'b1; req_aluop = op; req_op1 = a; req_op2 = b; req_tag = tag;
    for (int i = 0; i < 300 && !done; i++) begin
      if (req_ready) begin
        tick();
        exp_data.push_back(alu_f(op, a, b));
        exp_tag.push_back(tag);
        done = 1'b1;
      end else begin
        tick();
      end
    end
    req_valid = 1'b0;
    chk("req_accept", done, 1);
  endtask

  task automatic wait_results(input int n, input int budget);
    for (int i = 0; i < budget && got_data.size() < n; i++) tick();
  endtask

  task automatic compare_results(input string name);
    chk({name, "_count"}, got_data.size(), exp_data.size());
    for (int i = 0; i < exp_data.size(); i++) begin
      chk({name, "_data"}, (i < got_data.size()) ? got_data[i] : 32'hxxxx_xxxx, exp_data[i]);
      chk({name, "_tag"},  (i < got_tag.size())  ? got_tag[i]  : 4'hx, exp_tag[i]);
      chk({name, "_err"},  (i < got_err.size())  ? got_err[i]  : 1'bx, 1'b0);
    end
  endtask

  initial begin
    int sent;
    int cyc;
    bit acc;
    csr_seq[1] = 3'b000; csr_seq[2] = 3'b010; csr_seq[3] = 3'b100;
    csr_seq[4] = 3'b001; csr_seq[5] = 3'b000;

    reset_n = 1'b0; req_valid = 1'b0; req_aluop = '0; req_op1 = '0; req_op2 = '0;
    req_tag = '0; rsp_ready = 1'b0; alu_csr_out = 3'b000;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_csr_in", alu_csr_in, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_alu_op1", alu_op1, 0);
    reset_n = 1'b1;
    tick();
    chk("ready_after_release", req_ready, 1);

    // Single ADD 5+7 tag 3 with ALU flags already high: 6-cycle latency
    clear_q();
    alu_csr_out = 3'b111;
    req_valid = 1'b1; req_aluop = 4'd0; req_op1 = 32'd5; req_op2 = 32'd7; req_tag = 4'd3;
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("lat_rsp_valid", rsp_valid, (k == 5));
      chk("lat_csr_in", alu_csr_in, csr_seq[k]);
    end
    chk("single_data", rsp_data, 32'd12);
    chk("single_tag", rsp_tag, 4'd3);
    chk("single_err", rsp_err, 0);
    rsp_ready = 1'b1;
    tick();
    chk("single_drained", rsp_valid, 0);
    rsp_ready = 1'b0;

    // Burst of 6 with stalled ALU: 5 accepted, then backpressure
    clear_q();
    alu_csr_out = 3'b000;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1; req_aluop = 4'(i % 4); req_op1 = 32'(100 + 3 * i);
      req_op2 = 32'(i); req_tag = 4'(i);
      if (i < 5) begin
        chk("burst_ready", req_ready, 1);
        tick();
        exp_data.push_back(alu_f(req_aluop, req_op1, req_op2));
        exp_tag.push_back(req_tag);
      end else begin
        chk("burst_full", req_ready, 0);
      end
    end
    alu_csr_out = 3'b111;
    drive_req(4'd1, 32'd115, 32'd5, 4'd5);
    wait_results(6, 300);
    compare_results("burst");

    // Response backpressure: result FIFO fills, FSM parks in HOLD
    clear_q();
    rsp_ready = 1'b0;
    alu_csr_out = 3'b111;
    for (int i = 0; i < 5; i++)
      drive_req(4'(i % 4), 32'h1000_0000 + 32'(i), 32'h0000_0f0f * 32'(i + 1), 4'(8 + i));
    repeat (30) tick();
    chk("bp_rsp_valid", rsp_valid, 1);
    chk("bp_hold_protect", alu_csr_in, 3'b001);
    chk("bp_head_tag", rsp_tag, 4'd8);
    chk("bp_none_taken", got_data.size(), 0);
    rsp_ready = 1'b1;
    wait_results(5, 200);
    compare_results("bp");

    // Reset in the middle of WAIT with two commands queued
    clear_q();
    rsp_ready = 1'b1;
    alu_csr_out = 3'b011;
    for (int i = 0; i < 3; i++) drive_req(4'd0, 32'(7 + i), 32'd1, 4'(12 + i));
    repeat (8) tick();
    chk("wait_csr_in", alu_csr_in, 3'b000);
    chk("wait_op2", alu_op2, 32'd1);
    chk("wait_no_rsp", rsp_valid, 0);
    reset_n = 1'b0;
    #1;
    chk("midrst_csr_in", alu_csr_in, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_alu_op1", alu_op1, 0);
    chk("midrst_alu_op2", alu_op2, 0);
    tick();
    reset_n = 1'b1;
    alu_csr_out = 3'b111;
    repeat (20) tick();
    chk("postrst_no_stale", got_data.size(), 0);
    chk("postrst_rsp_valid", rsp_valid, 0);
    chk("postrst_req_ready", req_ready, 1);

    // Pointer wrap: 20 ops with random ALU and response readiness
    clear_q();
    sent = 0;
    cyc = 0;
    req_valid = 1'b0;
    while (got_data.size() < 20 && cyc < 4000) begin
      if (!req_valid && sent < 20) begin
        req_valid = 1'b1;
        req_aluop = 4'($urandom_range(0, 4));
        req_op1 = $urandom;
        req_op2 = $urandom;
        req_tag = 4'(sent);
      end
      alu_csr_out = 3'($urandom_range(0, 7));
      rsp_ready = 1'($urandom_range(0, 1));
      acc = req_valid && req_ready;
      tick();
      cyc++;
      if (acc) begin
        exp_data.push_back(alu_f(req_aluop, req_op1, req_op2));
        exp_tag.push_back(req_tag);
        sent++;
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    alu_csr_out = 3'b111;
    compare_results("wrap");

`ifdef FU_WDOG_EN
    // Watchdog: OP2 ready never arrives, command aborts with err
    clear_q();
    rsp_ready = 1'b1;
    alu_csr_out = 3'b001;
    drive_req(4'd0, 32'd9, 32'd9, 4'd6);
    wait_results(1, 300);
    chk("wdog_count", got_data.size(), 1);
    chk("wdog_err", (got_err.size() > 0) ? got_err[0] : 1'bx, 1);
    chk("wdog_data", (got_data.size() > 0) ? got_data[0] : 32'hxxxx_xxxx, 0);
    chk("wdog_tag", (got_tag.size() > 0) ? got_tag[0] : 4'hx, 4'd6);
    clear_q();
    alu_csr_out = 3'b111;
    drive_req(4'd0, 32'd2, 32'd3, 4'd7);
    wait_results(1, 100);
    compare_results("wdog_next");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
